// File: rtl/param_sync_fifo.sv
// Parametrised synchronous FIFO for the SCNN input path.
// Optional FWFT read port, fill level, thresholds, flush and sticky error flags.
`default_nettype none

module param_sync_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       write_en,
    input  logic [WIDTH-1:0]           w_data,
    input  logic                       read_en,
    output logic [WIDTH-1:0]           r_data,
    output logic                       r_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] LVL_AF   = PW'(AF_THRESH);
    localparam logic [PW-1:0] LVL_AE   = PW'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [PW-1:0] lvl;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] r_idx;
    logic          rd_ok;
    logic          wr_ok;
    logic          wr_req_bad;
    logic          rd_req_bad;

    assign lvl   = w_ptr_q - r_ptr_q;
    assign w_idx = w_ptr_q[AW-1:0];
    assign r_idx = r_ptr_q[AW-1:0];

    assign level        = lvl;
    assign full         = (lvl == LVL_FULL);
    assign empty        = (lvl == '0);
    assign almost_full  = (lvl >= LVL_AF);
    assign almost_empty = (lvl <= LVL_AE);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A full FIFO still takes a write when a pop frees a slot this cycle.
    assign rd_ok = read_en & ~empty;
    assign wr_ok = write_en & (~full | rd_ok);

    assign wr_req_bad = write_en & ~wr_ok & ~flush;
    assign rd_req_bad = read_en & ~rd_ok & ~flush;

    // Next-state for pointers and sticky error flags; flush beats traffic.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
        end else begin
            if (wr_ok) begin
                w_ptr_d = w_ptr_q + PW'(1);
            end
            if (rd_ok) begin
                r_ptr_d = r_ptr_q + PW'(1);
            end
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wr_req_bad) begin
            ovf_d = 1'b1;
        end
        if (rd_req_bad) begin
            udf_d = 1'b1;
        end
    end

    // Pointer and error-flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; left unreset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem_q[w_idx] <= w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented as soon as it is stored.
            always_comb begin
                r_data  = '0;
                r_valid = ~empty;
                if (!empty) begin
                    r_data = mem_q[r_idx];
                end
            end
        end else begin : g_std
            logic [WIDTH-1:0] r_data_q, r_data_d;
            logic             r_valid_q, r_valid_d;

            // Popped word is captured at the read edge.
            always_comb begin
                r_data_d  = r_data_q;
                r_valid_d = 1'b0;
                if (rd_ok && !flush) begin
                    r_data_d  = mem_q[r_idx];
                    r_valid_d = 1'b1;
                end
            end

            // Registered read-port outputs.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_data_q  <= r_data_d;
                    r_valid_q <= r_valid_d;
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: standard and FWFT instances share stimulus.
// Scoreboard queue tracks contents and expected read words.
`timescale 1ns/1ps

module tb_param_sync_fifo;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        write_en;
    logic [31:0] w_data;
    logic        read_en;
    logic        err_clr;

    logic [31:0] r_data0;
    logic        r_valid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic [4:0]  level0;

    logic [31:0] r_data1;
    logic        r_valid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0]  level1;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    logic [31:0] expq[$];

    param_sync_fifo #(.WIDTH(32), .DEPTH(16), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en(write_en), .w_data(w_data), .read_en(read_en),
        .r_data(r_data0), .r_valid(r_valid0),
        .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0),
        .level(level0), .overflow(ovf0), .underflow(udf0),
        .err_clr(err_clr)
    );

    param_sync_fifo #(.WIDTH(32), .DEPTH(16), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en(write_en), .w_data(w_data), .read_en(read_en),
        .r_data(r_data1), .r_valid(r_valid1),
        .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1),
        .level(level1), .overflow(ovf1), .underflow(udf1),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor for the registered read port.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            if (r_valid0 !== (expq.size() != 0)) begin
                errors++;
                $display("FAIL rvalid0 t=%0t got=%b want=%b",
                         $time, r_valid0, expq.size() != 0);
            end
            if (expq.size() != 0) begin
                logic [31:0] e;
                e = expq.pop_front();
                checks++;
                if (r_data0 !== e) begin
                    errors++;
                    $display("FAIL rdata0 t=%0t got=%h want=%h",
                             $time, r_data0, e);
                end
            end
        end
    end

    task automatic cyc(input logic we, input logic [31:0] wd,
                       input logic re, input logic fl,
                       input logic ec);
        int lvl;
        bit rd, wr;
        logic [31:0] v;
        write_en = we;
        w_data   = wd;
        read_en  = re;
        flush    = fl;
        err_clr  = ec;
        lvl = mq.size();
        rd  = re && (lvl > 0) && !fl;
        wr  = we && ((lvl < 16) || rd) && !fl;
        @(posedge clk);
        #1;
        if (fl) mq.delete();
        if (rd) begin
            v = mq.pop_front();
            expq.push_back(v);
        end
        if (wr) mq.push_back(wd);
        write_en = 1'b0;
        read_en  = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 0; write_en = 0; w_data = 0;
        read_en = 0; err_clr = 0;
        #12;
        checks++;
        if ({level0, empty0, full0, ae0, af0} !== {5'd0, 4'b1010}) begin
            errors++;
            $display("FAIL reset_status got=%h/%b%b%b%b want=0/1010",
                     level0, empty0, full0, ae0, af0);
        end
        checks++;
        if ({r_data0, r_valid0, ovf0, udf0} !== 35'd0) begin
            errors++;
            $display("FAIL reset_rd got=%h %b%b%b want=0 000",
                     r_data0, r_valid0, ovf0, udf0);
        end
        checks++;
        if ({r_valid1, empty1} !== 2'b01) begin
            errors++;
            $display("FAIL reset_fwft got=%b%b want=01",
                     r_valid1, empty1);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 32'(i), 0, 0, 0);
            checks++;
            if (level0 !== 5'(i) || af0 !== (i >= 14) ||
                ae0 !== (i <= 2)) begin
                errors++;
                $display("FAIL fill_lvl i=%0d got=%0d af=%b ae=%b",
                         i, level0, af0, ae0);
            end
        end
        checks++;
        if (full0 !== 1'b1 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got full=%b ovf=%b want 1 0",
                     full0, ovf0);
        end
        cyc(1, 32'hDEAD, 0, 0, 0);
        checks++;
        if (ovf0 !== 1'b1 || level0 !== 5'd16 || ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL overflow got ovf=%b lvl=%0d want 1 16",
                     ovf0, level0);
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, 0);
        end
        checks++;
        if (empty0 !== 1'b1 || udf0 !== 1'b0) begin
            errors++;
            $display("FAIL drain got empty=%b udf=%b want 1 0",
                     empty0, udf0);
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (udf0 !== 1'b1 || udf1 !== 1'b1) begin
            errors++;
            $display("FAIL underflow got=%b want=1", udf0);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if ({ovf0, udf0} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr got=%b%b want=00", ovf0, udf0);
        end
    endtask

    task automatic test_fwft();
        cyc(1, 32'hAB, 0, 0, 0);
        checks++;
        if (r_valid1 !== 1'b1 || r_data1 !== 32'hAB) begin
            errors++;
            $display("FAIL fwft_head got v=%b d=%h want 1 ab",
                     r_valid1, r_data1);
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (empty1 !== 1'b1 || r_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop got e=%b v=%b want 1 0",
                     empty1, r_valid1);
        end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 32'h100 + 32'(i), 0, 0, 0);
        end
        cyc(1, 32'h200, 1, 0, 0);
        checks++;
        if (level0 !== 5'd16 || ovf0 !== 1'b0 || full0 !== 1'b1) begin
            errors++;
            $display("FAIL full_rw got lvl=%0d ovf=%b want 16 0",
                     level0, ovf0);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 1, 0, 0);
        end
        cyc(1, 32'h300, 1, 0, 0);
        checks++;
        if (level0 !== 5'd1 || udf0 !== 1'b1) begin
            errors++;
            $display("FAIL empty_rw got lvl=%0d udf=%b want 1 1",
                     level0, udf0);
        end
        cyc(0, 0, 1, 0, 1);
    endtask

    task automatic test_flush_stream();
        for (int i = 0; i < 10; i++) begin
            cyc(1, 32'h400 + 32'(i), 0, 0, 0);
        end
        cyc(1, 32'hBAD, 0, 1, 0);
        checks++;
        if (level0 !== 5'd0 || empty0 !== 1'b1 ||
            r_valid0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL flush got lvl=%0d e=%b v=%b ovf=%b",
                     level0, empty0, r_valid0, ovf0);
        end
        cyc(1, 32'h1000, 0, 0, 0);
        for (int i = 1; i < 40; i++) begin
            cyc(1, 32'h1000 + 32'(i), 1, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (empty0 !== 1'b1 || level0 !== 5'd0) begin
            errors++;
            $display("FAIL stream_end got lvl=%0d want 0", level0);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1, 32'h500 + 32'(i), 0, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        checks++;
        if (level0 !== 5'd6 || udf0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst got lvl=%0d udf=%b want 6 1",
                     level0, udf0);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({level0, empty0, full0, ae0, af0} !== {5'd0, 4'b1010}) begin
            errors++;
            $display("FAIL midrst_status got=%0d/%b%b%b%b want 0/1010",
                     level0, empty0, full0, ae0, af0);
        end
        checks++;
        if ({r_data0, r_valid0, ovf0, udf0} !== 35'd0) begin
            errors++;
            $display("FAIL midrst_rd got=%h %b%b%b want 0 000",
                     r_data0, r_valid0, ovf0, udf0);
        end
        mq.delete();
        expq.delete();
        @(negedge clk);
        rst = 1'b1;
        cyc(1, 32'h55, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        checks++;
        if (udf0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set got=%b want=1", udf0);
        end
        cyc(0, 0, 0, 0, 1);
        checks++;
        if (udf0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_only got=%b want=0", udf0);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_fwft();
        test_simul();
        test_flush_stream();
        test_reset_mid();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d want=0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
